// File: rtl/cpu_on_board_pkg.sv
// Shared FSM state type and default timing constants for the on-board pushbutton inputs.
package cpu_on_board_pkg;

   localparam int unsigned DEB_CYCLES_DEF  = 1_000_000;
   localparam int unsigned LONG_CYCLES_DEF = 50_000_000;

   typedef enum logic [1:0] {
      ST_UP        = 2'd0,
      ST_WAIT_DOWN = 2'd1,
      ST_DOWN      = 2'd2,
      ST_WAIT_UP   = 2'd3
   } key_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM with stability counter.
// Optional hold counter and long-press strobe when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
   import cpu_on_board_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic CLOCK_50,
   input  logic RESET,
   input  logic key_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam int unsigned      CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   key_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc_c;
   logic             key_meta;
   logic             key_sync;

   // Synchronizer resets to the released level so reset never looks like a press.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   assign cnt_inc_c = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);

`ifdef KEY_LONG_PRESS_EN
   localparam int unsigned       HOLD_W   = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] hold_inc_c;

   assign hold_inc_c = (hold == HOLD_MAX) ? hold : hold + HOLD_W'(1);
`endif

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state         <= ST_UP;
         cnt           <= '0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
         hold          <= '0;
         long_press    <= 1'b0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
         long_press    <= 1'b0;
`endif
         case (state)
            ST_UP: begin
               if (!key_sync) begin
                  state <= ST_WAIT_DOWN;
                  cnt   <= '0;
               end
            end
            ST_WAIT_DOWN: begin
               if (key_sync) begin
                  state <= ST_UP;
               end else begin
                  cnt <= cnt_inc_c;
                  if (cnt_inc_c == CNT_LAST) begin
                     state       <= ST_DOWN;
                     pressed     <= 1'b1;
                     press_pulse <= 1'b1;
                  end
               end
            end
            ST_DOWN: begin
               if (key_sync) begin
                  state <= ST_WAIT_UP;
                  cnt   <= '0;
               end
`ifdef KEY_LONG_PRESS_EN
               hold <= hold_inc_c;
               if (hold != HOLD_MAX && hold_inc_c == HOLD_MAX) long_press <= 1'b1;
`endif
            end
            ST_WAIT_UP: begin
               if (!key_sync) begin
                  state <= ST_DOWN;
               end else begin
                  cnt <= cnt_inc_c;
               end
`ifdef KEY_LONG_PRESS_EN
               // Release clears the hold count on the way back to UP; otherwise keep counting.
               if (key_sync && cnt_inc_c == CNT_LAST) begin
                  hold <= '0;
               end else begin
                  hold <= hold_inc_c;
                  if (hold != HOLD_MAX && hold_inc_c == HOLD_MAX) long_press <= 1'b1;
               end
`endif
               if (key_sync && cnt_inc_c == CNT_LAST) begin
                  state         <= ST_UP;
                  pressed       <= 1'b0;
                  release_pulse <= 1'b1;
               end
            end
            default: state <= ST_UP;
         endcase
      end
   end

`ifndef KEY_LONG_PRESS_EN
   // Hold tracking compiled out; the strobe stays low whatever the threshold.
   if (LONG_CYCLES > 0) begin : g_long_off
      assign long_press = 1'b0;
   end else begin : g_long_none
      assign long_press = 1'b0;
   end
`endif

endmodule

// File: rtl/key_debouncer.sv
// NUM_KEYS independent pushbutton debouncers with press/release/long-press strobes.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debouncer
   import cpu_on_board_pkg::*;
#(
   parameter int unsigned NUM_KEYS    = 4,
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic                CLOCK_50,
   input  logic                RESET,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] long_press
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYCLES  (DEB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES)
      ) u_ch (
         .CLOCK_50      (CLOCK_50),
         .RESET         (RESET),
         .key_n         (KEY[i]),
         .pressed       (pressed[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_press    (long_press[i])
      );
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed latency/glitch/reset cases plus random key activity
// checked every cycle against a run-length debounce model.
module tb_key_debouncer;

   localparam int NK   = 4;
   localparam int DEB  = 8;
   localparam int LONG = 32;
`ifdef KEY_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic          CLOCK_50 = 1'b0;
   logic          RESET    = 1'b1;
   logic [NK-1:0] KEY      = '1;
   logic [NK-1:0] pressed, press_pulse, release_pulse, long_press;

   int n_vec = 0;
   int n_err = 0;

   key_debouncer #(
      .NUM_KEYS    (NK),
      .DEB_CYCLES  (DEB),
      .LONG_CYCLES (LONG)
   ) dut (
      .CLOCK_50      (CLOCK_50),
      .RESET         (RESET),
      .KEY           (KEY),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: the debounced level flips once DEB consecutive synchronized samples
   // (raw KEY delayed by two clocks) disagree with it.
   bit [NK-1:0]   kp1 = '1, kp2 = '1;
   int            run  [NK];
   int            hold [NK];
   logic [NK-1:0] m_pressed = '0, m_pp = '0, m_rp = '0, m_lp = '0;

   task automatic model_step();
      bit smp, was;
      for (int i = 0; i < NK; i++) begin
         m_pp[i] = 1'b0;
         m_rp[i] = 1'b0;
         m_lp[i] = 1'b0;
         if (RESET) begin
            kp1[i] = 1'b1; kp2[i] = 1'b1;
            run[i] = 0; hold[i] = 0; m_pressed[i] = 1'b0;
         end else begin
            smp = kp2[i];
            kp2[i] = kp1[i];
            kp1[i] = KEY[i];
            was = m_pressed[i];
            // active-low key: a sample equal to the current level means disagreement
            if (smp == was) run[i]++;
            else run[i] = 0;
            if (run[i] == DEB) begin
               run[i] = 0;
               hold[i] = 0;
               m_pressed[i] = !was;
               if (was) m_rp[i] = 1'b1;
               else     m_pp[i] = 1'b1;
            end else if (was && hold[i] < LONG) begin
               hold[i]++;
               if (hold[i] == LONG) m_lp[i] = LONG_EN;
            end
         end
      end
   endtask

   always @(posedge CLOCK_50) begin
      model_step();
      #1;
      chk("pressed",       32'(pressed),       32'(m_pressed));
      chk("press_pulse",   32'(press_pulse),   32'(m_pp));
      chk("release_pulse", 32'(release_pulse), 32'(m_rp));
      chk("long_press",    32'(long_press),    32'(m_lp));
   end

   // Counts falling edges until the chosen strobe of key idx is seen; limit+1 on timeout.
   task automatic wait_for(input int which, input int idx, input int limit, output int n);
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n <= limit) begin
         @(negedge CLOCK_50);
         n++;
         case (which)
            0:       hit = press_pulse[idx];
            1:       hit = release_pulse[idx];
            default: hit = long_press[idx];
         endcase
      end
   endtask

   initial begin
      int n, pulses, hi;
      int glitch [4] = '{5, 3, 5, 15};

      repeat (3) @(negedge CLOCK_50);
      chk("reset_outputs", 32'({pressed, press_pulse, release_pulse, long_press}), 0);
      RESET = 1'b0;
      repeat (4) @(negedge CLOCK_50);

      // Short glitches on KEY[1] must be filtered completely.
      pulses = 0; hi = 0;
      for (int s = 0; s < 4; s++) begin
         KEY[1] = (s % 2 == 1) || (s == 3);
         for (int c = 0; c < glitch[s]; c++) begin
            @(negedge CLOCK_50);
            pulses += $countones({press_pulse, release_pulse, long_press});
            hi     += int'(pressed[1]);
         end
      end
      chk("glitch_pulses", pulses, 0);
      chk("glitch_pressed", hi, 0);

      // Clean press on KEY[0].
      KEY[0] = 1'b0;
      wait_for(0, 0, 20, n);
      chk("press0_latency", n, DEB + 2);
      chk("press0_level", 32'(pressed[0]), 1);
      @(negedge CLOCK_50);
      chk("press0_one_cycle", 32'(press_pulse[0]), 0);

      // Long hold on KEY[2].
      KEY[2] = 1'b0;
      wait_for(0, 2, 20, n);
      chk("press2_latency", n, DEB + 2);
      if (LONG_EN) begin
         wait_for(2, 2, 60, n);
         chk("long2_latency", n, LONG);
      end
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLOCK_50);
         pulses += int'(long_press[2]);
      end
      chk("long2_extra", pulses, 0);

      // Simultaneous release of KEY[0] and KEY[3].
      KEY[3] = 1'b0;
      wait_for(0, 3, 20, n);
      chk("press3_latency", n, DEB + 2);
      repeat (3) @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      KEY[3] = 1'b1;
      wait_for(1, 0, 20, n);
      chk("release0_latency", n, DEB + 2);
      chk("release3_same_cycle", 32'(release_pulse[3]), 1);
      chk("release_both_low", 32'({pressed[3], pressed[0]}), 0);
      KEY[2] = 1'b1;
      wait_for(1, 2, 20, n);
      chk("release2_latency", n, DEB + 2);

      // Reset in the middle of a debounce on KEY[1], key kept low throughout.
      KEY[1] = 1'b0;
      repeat (6) @(negedge CLOCK_50);
      RESET = 1'b1;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLOCK_50);
         pulses += $countones({press_pulse, release_pulse, long_press, pressed});
      end
      chk("reset_no_pulse", pulses, 0);
      RESET = 1'b0;
      wait_for(0, 1, 20, n);
      chk("press1_after_reset", n, DEB + 2);
      KEY[1] = 1'b1;
      wait_for(1, 1, 20, n);
      chk("release1_latency", n, DEB + 2);

      // Random activity: mix of short glitches, real presses, long holds and resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLOCK_50);
         if (RESET) begin
            if ($urandom_range(0, 2) == 0) RESET = 1'b0;
         end else if ($urandom_range(0, 699) == 0) begin
            RESET = 1'b1;
         end
         for (int i = 0; i < NK; i++)
            if ($urandom_range(0, 13) == 0) KEY[i] = ~KEY[i];
      end
      RESET = 1'b0;
      KEY = '1;
      repeat (DEB + 5) @(negedge CLOCK_50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
